// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF subframe assembly path.
package spdif_pkg;

  localparam int unsigned SUBFRAME_BITS    = 28;
  localparam int unsigned AUX_AUDIO_W      = 24;
  localparam int unsigned V_IDX            = 24;
  localparam int unsigned U_IDX            = 25;
  localparam int unsigned C_IDX            = 26;
  localparam int unsigned P_IDX            = 27;
  localparam int unsigned CS_BITS          = 32;
  localparam int unsigned FRAMES_PER_BLOCK = 192;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } channel_e;

endpackage

// File: rtl/spdif_cs_collector.sv
// Captures the first 32 channel-status bits of channel A in each 192-frame block.
module spdif_cs_collector
  import spdif_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               complete,
  input  logic               chan,
  input  logic [7:0]         frame,
  input  logic               c_bit,
  output logic [CS_BITS-1:0] cs_word,
  output logic               cs_valid
);

  logic [CS_BITS-1:0] cs_shift;
  logic [CS_BITS-1:0] cs_shift_next;
  logic               hit;

  assign hit = complete && (chan == CH_A) && (frame < 8'(CS_BITS));

  // Frame 0 starts a fresh block, so stale bits are cleared before the merge.
  always_comb begin
    cs_shift_next = (frame == 8'd0) ? '0 : cs_shift;
    cs_shift_next[frame[4:0]] = c_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_shift <= '0;
      cs_word  <= '0;
      cs_valid <= 1'b0;
    end else begin
      cs_valid <= 1'b0;
      if (hit) begin
        cs_shift <= cs_shift_next;
        if (frame == 8'(CS_BITS - 1)) begin
          cs_word  <= cs_shift_next;
          cs_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spdif_subframe_assembler.sv
// Packs the decoder's serial bit stream into parallel subframes with a valid/ready output
// and collects channel-status bits.
module spdif_subframe_assembler
  import spdif_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 255,
  parameter int unsigned SAMPLE_W   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  input  logic                vin,
  input  logic [7:0]          frame_in,
  input  logic                channel_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                chan_out,
  output logic [7:0]          frame_out,
  output logic                v_out,
  output logic                u_out,
  output logic                c_out,
  output logic                parity_err,
  output logic                vout,
  input  logic                rdy,
  output logic [CS_BITS-1:0]  cs_word,
  output logic                cs_valid,
  output logic                err_short,
  output logic                err_overflow
);

  logic [4:0]               bit_idx;
  logic [SUBFRAME_BITS-1:0] shreg;
  logic [SUBFRAME_BITS-1:0] shifted;
  logic [7:0]               gap_cnt;
  logic                     last_ch;
  logic                     ch_switch;
  logic                     complete;
  logic                     timeout;
  logic                     accept;

  // Full subframe including the bit arriving this cycle; first bit lands at bit 0.
  assign shifted   = {din, shreg[SUBFRAME_BITS-1:1]};
  assign ch_switch = vin && (bit_idx != 5'd0) && (channel_in != last_ch);
  assign complete  = vin && !ch_switch && (bit_idx == 5'(SUBFRAME_BITS - 1));
  assign timeout   = !vin && (bit_idx != 5'd0) && (gap_cnt == 8'(GAP_CYCLES));
  assign accept    = complete && (!vout || rdy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx      <= '0;
      shreg        <= '0;
      gap_cnt      <= '0;
      last_ch      <= 1'b0;
      sample_out   <= '0;
      chan_out     <= 1'b0;
      frame_out    <= '0;
      v_out        <= 1'b0;
      u_out        <= 1'b0;
      c_out        <= 1'b0;
      parity_err   <= 1'b0;
      vout         <= 1'b0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_short    <= ch_switch || timeout;
      err_overflow <= complete && vout && !rdy;
      if (vin) begin
        shreg   <= shifted;
        last_ch <= channel_in;
        gap_cnt <= '0;
        // A channel switch restarts the subframe with this bit already counted.
        if (ch_switch) begin
          bit_idx <= 5'd1;
        end else if (complete) begin
          bit_idx <= 5'd0;
        end else begin
          bit_idx <= bit_idx + 5'd1;
        end
      end else begin
        if (gap_cnt != 8'hFF) begin
          gap_cnt <= gap_cnt + 8'd1;
        end
        if (timeout) begin
          bit_idx <= 5'd0;
        end
      end
      if (accept) begin
        sample_out <= shifted[SAMPLE_W-1:0];
        v_out      <= shifted[V_IDX];
        u_out      <= shifted[U_IDX];
        c_out      <= shifted[C_IDX];
        parity_err <= ^shifted;
        chan_out   <= channel_in;
        frame_out  <= frame_in;
        vout       <= 1'b1;
      end else if (vout && rdy) begin
        vout <= 1'b0;
      end
    end
  end

  spdif_cs_collector u_cs_collector (
    .clk      (clk),
    .rst      (rst),
    .complete (complete),
    .chan     (channel_in),
    .frame    (frame_in),
    .c_bit    (shifted[C_IDX]),
    .cs_word  (cs_word),
    .cs_valid (cs_valid)
  );

endmodule

// File: tb/tb_spdif_subframe_assembler.sv
// Directed and randomized checks of spdif_subframe_assembler against a subframe-level model.
module tb_spdif_subframe_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        vin = 1'b0;
  logic [7:0]  frame_in = '0;
  logic        channel_in = 1'b0;
  logic [23:0] sample_out;
  logic        chan_out;
  logic [7:0]  frame_out;
  logic        v_out, u_out, c_out, parity_err, vout;
  logic        rdy = 1'b0;
  logic [31:0] cs_word;
  logic        cs_valid, err_short, err_overflow;

  int checks = 0;
  int failures = 0;
  int cs_pulses = 0;

  spdif_subframe_assembler dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .vin          (vin),
    .frame_in     (frame_in),
    .channel_in   (channel_in),
    .sample_out   (sample_out),
    .chan_out     (chan_out),
    .frame_out    (frame_out),
    .v_out        (v_out),
    .u_out        (u_out),
    .c_out        (c_out),
    .parity_err   (parity_err),
    .vout         (vout),
    .rdy          (rdy),
    .cs_word      (cs_word),
    .cs_valid     (cs_valid),
    .err_short    (err_short),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cs_valid) cs_pulses++;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Subframe as transmitted: audio/aux, V, U, C, then P for even parity unless corrupted.
  function automatic logic [27:0] make_sf(input logic [23:0] s, input logic v, input logic u,
                                          input logic c, input logic bad_p);
    logic [26:0] body;
    logic        p;
    body = {c, u, v, s};
    p = (($countones(body) % 2) == 1) ^ bad_p;
    return {p, body};
  endfunction

  task automatic send_bit(input logic b, input logic ch, input logic [7:0] fr);
    din = b; vin = 1'b1; channel_in = ch; frame_in = fr;
    @(negedge clk);
    vin = 1'b0;
  endtask

  task automatic send_sf(input logic [27:0] sf, input logic ch, input logic [7:0] fr);
    for (int i = 0; i < 28; i++) send_bit(sf[i], ch, fr);
  endtask

  task automatic expect_out(input string tag, input logic [27:0] sf, input logic ch,
                            input logic [7:0] fr);
    check({tag, ".vout"}, 32'(vout), 32'd1);
    check({tag, ".sample"}, 32'(sample_out), 32'(sf % (1 << 24)));
    check({tag, ".vuc"}, 32'({v_out, u_out, c_out}), 32'({sf[24], sf[25], sf[26]}));
    check({tag, ".parity"}, 32'(parity_err), 32'(($countones(sf) % 2) != 0));
    check({tag, ".chan"}, 32'(chan_out), 32'(ch));
    check({tag, ".frame"}, 32'(frame_out), 32'(fr));
  endtask

  initial begin
    logic [27:0] sf, sf2;
    logic [31:0] pattern;
    logic        ch;
    logic [7:0]  fr;
    bit          seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset.vout", 32'(vout), 32'd0);
    check("reset.sample", 32'(sample_out), 32'd0);
    check("reset.cs_word", cs_word, 32'd0);
    check("reset.errs", 32'({err_short, err_overflow, cs_valid}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic channel-A subframe, held until the sink is ready
    sf = make_sf(24'hABCDE1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_sf(sf, 1'b0, 8'd5);
    expect_out("basic", sf, 1'b0, 8'd5);
    check("basic.parity_fixed", 32'(parity_err), 32'd0);
    check("basic.u_fixed", 32'(u_out), 32'd1);
    @(negedge clk);
    check("basic.hold", 32'(vout), 32'd1);
    rdy = 1'b1;
    @(negedge clk);
    check("basic.drop", 32'(vout), 32'd0);

    // Corrupted parity still delivered
    sf = make_sf(24'hABCDE1, 1'b0, 1'b1, 1'b0, 1'b1);
    send_sf(sf, 1'b0, 8'd5);
    expect_out("badpar", sf, 1'b0, 8'd5);
    check("badpar.flag", 32'(parity_err), 32'd1);
    @(negedge clk);

    // Channel switch mid-subframe
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0, 8'd9);
    sf = make_sf(24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    send_bit(sf[0], 1'b1, 8'd10);
    check("chsw.err_short", 32'(err_short), 32'd1);
    for (int i = 1; i < 28; i++) begin
      send_bit(sf[i], 1'b1, 8'd10);
      if (i == 1) check("chsw.err_short_pulse", 32'(err_short), 32'd0);
    end
    expect_out("chsw", sf, 1'b1, 8'd10);
    @(negedge clk);

    // Overflow: second completion dropped while the first is held
    rdy = 1'b0;
    sf = make_sf(24'h123456, 1'b1, 1'b0, 1'b1, 1'b0);
    send_sf(sf, 1'b0, 8'd7);
    expect_out("ovf.first", sf, 1'b0, 8'd7);
    sf2 = make_sf(24'h654321, 1'b0, 1'b1, 1'b0, 1'b0);
    send_sf(sf2, 1'b1, 8'd7);
    check("ovf.err", 32'(err_overflow), 32'd1);
    expect_out("ovf.held", sf, 1'b0, 8'd7);
    @(negedge clk);
    check("ovf.err_pulse", 32'(err_overflow), 32'd0);
    rdy = 1'b1;
    @(negedge clk);
    check("ovf.single_xfer", 32'(vout), 32'd0);

    // Randomized subframes with a free-running sink
    for (int n = 0; n < 16; n++) begin
      ch = 1'($urandom);
      fr = 8'($urandom_range(0, 191));
      sf = make_sf(24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 3) == 0));
      send_sf(sf, ch, fr);
      expect_out("rand", sf, ch, fr);
      check("rand.no_err", 32'({err_short, err_overflow}), 32'd0);
    end
    @(negedge clk);

    // Channel-status block; channel-B C bits are the inverse and must be ignored
    pattern = 32'h8000_0004;
    cs_pulses = 0;
    for (int f = 0; f < 32; f++) begin
      sf = make_sf(24'($urandom), 1'b0, 1'b0, pattern[f], 1'($urandom));
      send_sf(sf, 1'b0, 8'(f));
      if (f == 31) check("cs.valid_at_31", 32'(cs_valid), 32'd1);
      sf = make_sf(24'($urandom), 1'b0, 1'b0, ~pattern[f], 1'b0);
      send_sf(sf, 1'b1, 8'(f));
    end
    repeat (2) @(negedge clk);
    check("cs.pulses", 32'(cs_pulses), 32'd1);
    check("cs.word", cs_word, pattern);

    // Gap timeout discards a partial subframe
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 8'd40);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err_short) seen = 1'b1;
    end
    check("gap.not_early", 32'(seen), 32'd0);
    for (int i = 0; i < 150 && !seen; i++) begin
      @(negedge clk);
      if (err_short) seen = 1'b1;
    end
    check("gap.err_short", 32'(seen), 32'd1);
    sf = make_sf(24'h0F0F0F, 1'b1, 1'b1, 1'b0, 1'b0);
    send_sf(sf, 1'b0, 8'd41);
    expect_out("gap.after", sf, 1'b0, 8'd41);

    // Asynchronous reset mid-subframe, vin ignored while in reset
    rdy = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0, 8'd50);
    #2 rst = 1'b1;
    #1;
    check("arst.vout", 32'(vout), 32'd0);
    check("arst.sample", 32'(sample_out), 32'd0);
    check("arst.cs_word", cs_word, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1, 8'd51);
    rst = 1'b0;
    @(negedge clk);
    sf = make_sf(24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    send_sf(sf, 1'b0, 8'd52);
    expect_out("arst.after", sf, 1'b0, 8'd52);
    check("arst.no_err", 32'({err_short, err_overflow}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
